anneal_step_ctr: RTL



---
 rtl/anneal_step_ctr.sv | 129 ++++++++++++
 1 files changed

// File: rtl/anneal_step_ctr.sv
// SSQA run sequencer: NUM_STEPS dwell steps per trial, num_trials trials, abort and restart.
// Optional macro ANNEAL_STEP_CTR_PAUSE_EN adds a pause input that stalls RUN in place.
module anneal_step_ctr #(
  parameter int NUM_STEPS = 10,
  parameter int STEP_W    = 4,
  parameter int CYC_W     = 8,
  parameter int TRIAL_W   = 8
) (
  input  logic               clk,
  input  logic               rst_sys,
  input  logic               start,
  input  logic               abort,
`ifdef ANNEAL_STEP_CTR_PAUSE_EN
  input  logic               pause,
`endif
  input  logic [CYC_W-1:0]   cycles_per_step,
  input  logic [TRIAL_W-1:0] num_trials,
  output logic               comp_enable,
  output logic [STEP_W-1:0]  step_idx,
  output logic               step_tick,
  output logic [TRIAL_W-1:0] trial_idx,
  output logic               trial_done,
  output logic               busy,
  output logic               finish
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, GAP = 2'd2, DONE = 2'd3} state_e;

  state_e             state_q, state_d;
  logic [CYC_W-1:0]   cps_q, cps_d;
  logic [TRIAL_W-1:0] ntr_q, ntr_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [TRIAL_W-1:0] trial_q, trial_d;

  logic stall;
`ifdef ANNEAL_STEP_CTR_PAUSE_EN
  assign stall = pause;
`else
  assign stall = 1'b0;
`endif

  logic last_cyc, last_step, last_trial;
  assign last_cyc   = (cyc_q == cps_q - CYC_W'(1));
  assign last_step  = (step_q == STEP_W'(NUM_STEPS - 1));
  assign last_trial = (trial_q == ntr_q - TRIAL_W'(1));

  always_ff @(posedge clk or posedge rst_sys) begin
    if (rst_sys) begin
      state_q <= IDLE;
      cps_q   <= '0;
      ntr_q   <= '0;
      cyc_q   <= '0;
      step_q  <= '0;
      trial_q <= '0;
    end else begin
      state_q <= state_d;
      cps_q   <= cps_d;
      ntr_q   <= ntr_d;
      cyc_q   <= cyc_d;
      step_q  <= step_d;
      trial_q <= trial_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cps_d   = cps_q;
    ntr_d   = ntr_q;
    cyc_d   = cyc_q;
    step_d  = step_q;
    trial_d = trial_q;
    if (abort) begin
      state_d = IDLE;
      cyc_d   = '0;
      step_d  = '0;
      trial_d = '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            // Zero config means "one": keeps the terminal compares well-defined.
            cps_d   = (cycles_per_step == '0) ? CYC_W'(1) : cycles_per_step;
            ntr_d   = (num_trials == '0) ? TRIAL_W'(1) : num_trials;
            cyc_d   = '0;
            step_d  = '0;
            trial_d = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          if (!stall) begin
            if (last_cyc) begin
              cyc_d = '0;
              if (!last_step) begin
                step_d = step_q + STEP_W'(1);
              end else begin
                step_d  = '0;
                state_d = GAP;
              end
            end else begin
              cyc_d = cyc_q + CYC_W'(1);
            end
          end
        end
        GAP: begin
          if (last_trial) begin
            state_d = DONE;
          end else begin
            trial_d = trial_q + TRIAL_W'(1);
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    comp_enable = (state_q == RUN) && !stall;
    step_tick   = (state_q == RUN) && !stall && !abort && last_cyc;
    trial_done  = (state_q == GAP) && !abort;
    busy        = (state_q == RUN) || (state_q == GAP);
    finish      = (state_q == DONE);
    step_idx    = step_q;
    trial_idx   = trial_q;
  end

endmodule
